// File: rtl/alu_seq_controller.sv
// Sequencing FSM for a multi-cycle ALU datapath: load A, load B, a per-opcode
// number of execute cycles, result store, then a one-cycle done pulse.
module alu_seq_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] opcode,
  output logic [1:0] opcode_q,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, STORE, DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] opcode_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] exec_last;

  // Counter preload is N-1: mul runs 4 EXEC cycles, div 6, add/sub 1.
  always_comb begin
    case (opcode_q)
      2'b01:   exec_last = 3'd3;
      2'b11:   exec_last = 3'd5;
      default: exec_last = 3'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD_A;
          opcode_d = opcode;
        end
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: begin
        cnt_d   = exec_last;
        state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == 3'd0) begin
          state_d = STORE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      STORE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      opcode_q <= 2'b00;
      cnt_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
    end
  end

  // Masked by rst so nothing fires in the cycle a reset arrives mid-operation.
  assign ld_a   = !rst && (state_q == LOAD_A);
  assign ld_b   = !rst && (state_q == LOAD_B);
  assign ld_out = !rst && (state_q == STORE);
  assign done   = !rst && (state_q == DONE);
  assign busy   = !rst && (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq_controller.sv
// Self-checking bench for alu_seq_controller: directed scenarios plus a
// randomized run, all compared against a timeline model derived from N per opcode.
module tb_alu_seq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] opcode;
  logic [1:0] opcode_q;
  logic       ld_a, ld_b, ld_out, busy, done;
  logic [4:0] obs;
  logic [4:0] exp_v;

  int errors = 0;
  int checks = 0;

  alu_seq_controller dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .opcode   (opcode),
    .opcode_q (opcode_q),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .ld_out   (ld_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  assign obs = {ld_a, ld_b, ld_out, done, busy};

  function automatic int n_of(input logic [1:0] op);
    case (op)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 1;
      default: return 6;
    endcase
  endfunction

  // Expected {ld_a, ld_b, ld_out, done, busy} in cycle c after the accepting edge.
  function automatic logic [4:0] model_out(input int n, input int c);
    logic [4:0] r;
    r    = '0;
    r[4] = (c == 1);
    r[3] = (c == 2);
    r[2] = (c == n + 3);
    r[1] = (c == n + 4);
    r[0] = (c >= 1) && (c <= n + 4);
    return r;
  endfunction

  task automatic issue_start(input logic [1:0] op);
    @(negedge clk);
    opcode = op;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; opcode = 2'b11;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 5'b0) begin errors++; $display("[TB] FAIL reset_outputs obs=%b exp=%b", obs, 5'b0); end
      checks++;
      if (opcode_q !== 2'b00) begin errors++; $display("[TB] FAIL reset_opcode_q got=%b exp=00", opcode_q); end
    end
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 5'b0) begin errors++; $display("[TB] FAIL reset_idle obs=%b exp=%b", obs, 5'b0); end
  endtask

  task automatic test_add();
    issue_start(2'b00);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      exp_v = model_out(1, c);
      checks++;
      if (obs !== exp_v) begin errors++; $display("[TB] FAIL add c=%0d obs=%b exp=%b", c, obs, exp_v); end
      checks++;
      if (opcode_q !== 2'b00) begin errors++; $display("[TB] FAIL add_opcode_q c=%0d got=%b exp=00", c, opcode_q); end
    end
  endtask

  task automatic test_div_opcode_flip();
    issue_start(2'b11);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      exp_v = model_out(6, c);
      checks++;
      if (obs !== exp_v) begin errors++; $display("[TB] FAIL div c=%0d obs=%b exp=%b", c, obs, exp_v); end
      checks++;
      if (opcode_q !== 2'b11) begin errors++; $display("[TB] FAIL div_opcode_q c=%0d got=%b exp=11", c, opcode_q); end
      if (c == 4) opcode = 2'b00;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    opcode = 2'b01;
    start  = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      exp_v = model_out(4, ((c - 1) % 9) + 1);
      checks++;
      if (obs !== exp_v) begin errors++; $display("[TB] FAIL mul_held c=%0d obs=%b exp=%b", c, obs, exp_v); end
      if (c == 17) start = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    issue_start(2'b10);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      exp_v = model_out(1, c);
      checks++;
      if (obs !== exp_v) begin errors++; $display("[TB] FAIL sub_pre_rst c=%0d obs=%b exp=%b", c, obs, exp_v); end
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 5'b0) begin errors++; $display("[TB] FAIL sub_rst obs=%b exp=%b", obs, 5'b0); end
    checks++;
    if (opcode_q !== 2'b00) begin errors++; $display("[TB] FAIL sub_rst_opcode_q got=%b exp=00", opcode_q); end
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b1; opcode = 2'b01;
    @(negedge clk);
    checks++;
    if (obs !== 5'b0) begin errors++; $display("[TB] FAIL sub_after_rst obs=%b exp=%b", obs, 5'b0); end
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      exp_v = model_out(4, c);
      checks++;
      if (obs !== exp_v) begin errors++; $display("[TB] FAIL restart c=%0d obs=%b exp=%b", c, obs, exp_v); end
      checks++;
      if (opcode_q !== 2'b01) begin errors++; $display("[TB] FAIL restart_opcode_q c=%0d got=%b exp=01", c, opcode_q); end
    end
  endtask

  task automatic test_start_in_done();
    issue_start(2'b00);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      exp_v = model_out(1, c);
      checks++;
      if (obs !== exp_v) begin errors++; $display("[TB] FAIL start_in_done c=%0d obs=%b exp=%b", c, obs, exp_v); end
      checks++;
      if (opcode_q !== 2'b00) begin errors++; $display("[TB] FAIL start_in_done_opcode_q c=%0d got=%b exp=00", c, opcode_q); end
      if (c == 5) begin start = 1'b1; opcode = 2'b11; end
      if (c == 6) start = 1'b0;
    end
  endtask

  task automatic test_random();
    int accepted = 0;
    int seen_done = 0;
    for (int k = 0; k < 30; k++) begin
      logic [1:0] op;
      int n;
      int gap;
      op  = 2'($urandom_range(0, 3));
      n   = n_of(op);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if (obs !== 5'b0) begin errors++; $display("[TB] FAIL rand_gap op#%0d obs=%b exp=%b", k, obs, 5'b0); end
      end
      issue_start(op);
      accepted++;
      for (int c = 1; c <= n + 5; c++) begin
        @(negedge clk);
        exp_v = model_out(n, c);
        checks++;
        if (obs !== exp_v) begin errors++; $display("[TB] FAIL rand op#%0d opc=%b c=%0d obs=%b exp=%b", k, op, c, obs, exp_v); end
        checks++;
        if ($countones(obs[4:1]) > 1) begin errors++; $display("[TB] FAIL rand_onehot op#%0d c=%0d strobes=%b exp=at most one", k, c, obs[4:1]); end
        checks++;
        if (opcode_q !== op) begin errors++; $display("[TB] FAIL rand_opcode_q op#%0d c=%0d got=%b exp=%b", k, c, opcode_q, op); end
        if (done === 1'b1) seen_done++;
        if (c <= n + 4) begin
          start  = 1'($urandom_range(0, 1));
          opcode = 2'($urandom_range(0, 3));
        end else begin
          start = 1'b0;
        end
      end
    end
    checks++;
    if (seen_done != accepted) begin errors++; $display("[TB] FAIL rand_done_count got=%0d exp=%0d", seen_done, accepted); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = 2'b00;
    $display("[TB] alu_seq_controller bench starting");
    test_reset();
    test_add();
    test_div_opcode_flip();
    test_back_to_back();
    test_reset_mid();
    test_start_in_done();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
